// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: FSM states, kernel geometry and default pixel/weight types.
package cnn_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int PIX_W       = 8;
    localparam int WGT_W       = 8;

    typedef logic        [PIX_W-1:0] pixel_t;
    typedef logic signed [WGT_W-1:0] weight_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } conv_state_e;

    // Row-major tap number inside the 3x3 window (row 0 = oldest row).
    function automatic int tap_index(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/line_buffer_3x3.sv
// Two-row line buffer plus 3x3 window register with raster counters and window-valid tagging.
module line_buffer_3x3
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_en,
    input  logic                                i_accept,
    input  logic [DATA_WIDTH-1:0]               i_data,
    output logic [KERNEL_TAPS*DATA_WIDTH-1:0]   o_window,
    output logic                                o_win_valid,
    output logic                                o_win_last,
    output logic                                o_frame_end
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    logic [DATA_WIDTH-1:0] r_row_top [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_row_mid [IMG_WIDTH];
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  w_col_end;
    logic                  w_row_end;

    logic [DATA_WIDTH-1:0] r_s0_pix;
    logic [DATA_WIDTH-1:0] r_s0_top;
    logic [DATA_WIDTH-1:0] r_s0_mid;
    logic                  r_s0_shift;
    logic                  r_s0_valid;
    logic                  r_s0_last;

    logic [DATA_WIDTH-1:0] r_win [KERNEL_TAPS];
    logic                  r_win_valid;
    logic                  r_win_last;

    assign w_col_end   = (r_col == COL_MAX);
    assign w_row_end   = (r_row == ROW_MAX);
    assign o_frame_end = i_accept & w_col_end & w_row_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Each column slot holds the two previous rows; the new pixel pushes them up by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < IMG_WIDTH; c++) begin
                r_row_top[c] <= '0;
                r_row_mid[c] <= '0;
            end
        end else if (i_accept) begin
            r_row_top[r_col] <= r_row_mid[r_col];
            r_row_mid[r_col] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_pix   <= '0;
            r_s0_top   <= '0;
            r_s0_mid   <= '0;
            r_s0_shift <= 1'b0;
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else if (i_en) begin
            r_s0_shift <= i_accept;
            r_s0_valid <= i_accept & (r_col >= COL_TWO) & (r_row >= ROW_TWO);
            r_s0_last  <= o_frame_end;
            if (i_accept) begin
                r_s0_pix <= i_data;
                r_s0_top <= r_row_top[r_col];
                r_s0_mid <= r_row_mid[r_col];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < KERNEL_TAPS; t++) begin
                r_win[t] <= '0;
            end
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (i_en) begin
            r_win_valid <= r_s0_valid;
            r_win_last  <= r_s0_last;
            if (r_s0_shift) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[tap_index(r, 0)] <= r_win[tap_index(r, 1)];
                    r_win[tap_index(r, 1)] <= r_win[tap_index(r, 2)];
                end
                r_win[tap_index(0, 2)] <= r_s0_top;
                r_win[tap_index(1, 2)] <= r_s0_mid;
                r_win[tap_index(2, 2)] <= r_s0_pix;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < KERNEL_TAPS; gi++) begin : g_win_pack
            assign o_window[gi*DATA_WIDTH +: DATA_WIDTH] = r_win[gi];
        end
    endgenerate

    assign o_win_valid = r_win_valid;
    assign o_win_last  = r_win_last;

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 valid-mode convolution with NUM_FILTERS parallel kernels, stall-able pipeline
// and optional ReLU.
module conv3x3_stream_engine
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH    = 28,
    parameter int IMG_HEIGHT   = 28,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_FILTERS  = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int RELU_EN      = 1,
    localparam int FW          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_ready,
    output logic                             o_valid,
    output logic [NUM_FILTERS*ACC_WIDTH-1:0] o_result,
    output logic                             o_last,
    input  logic                             i_ready,
    input  logic                             i_wr_en,
    input  logic [FW-1:0]                    i_wr_filter,
    input  logic [3:0]                       i_wr_idx,
    input  logic [WEIGHT_WIDTH-1:0]          i_wr_data,
    output logic                             o_busy
);

    localparam int PW = DATA_WIDTH + 1 + WEIGHT_WIDTH;
    localparam logic [FW:0] NF_L = (FW + 1)'(NUM_FILTERS);

    conv_state_e r_state;
    conv_state_e w_state_next;

    logic w_en;
    logic w_accept;
    logic w_wr_ok;
    logic w_frame_end;

    logic [KERNEL_TAPS*DATA_WIDTH-1:0] w_window;
    logic                              w_win_valid;
    logic                              w_win_last;

    logic signed [WEIGHT_WIDTH-1:0] r_weight [NUM_FILTERS][KERNEL_TAPS];
    logic signed [PW-1:0]           w_pix_ext [KERNEL_TAPS];
    logic signed [PW-1:0]           r_prod [NUM_FILTERS][KERNEL_TAPS];
    logic                           r_s2_valid;
    logic                           r_s2_last;
    logic signed [ACC_WIDTH-1:0]    w_sum [NUM_FILTERS];
    logic signed [ACC_WIDTH-1:0]    r_result [NUM_FILTERS];
    logic                           r_valid;
    logic                           r_last;

    // One enable freezes every stage at once, so a stalled output never loses a result.
    assign w_en     = ~r_valid | i_ready;
    assign o_ready  = w_en & (r_state != ST_DRAIN);
    assign w_accept = i_valid & o_ready;
    assign o_busy   = (r_state != ST_IDLE);

    line_buffer_3x3 #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_en),
        .i_accept    (w_accept),
        .i_data      (i_data),
        .o_window    (w_window),
        .o_win_valid (w_win_valid),
        .o_win_last  (w_win_last),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_STREAM;
            ST_STREAM: if (w_frame_end) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (r_valid & i_ready & r_last) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_wr_ok = i_wr_en & (r_state == ST_IDLE) & (i_wr_idx < 4'd9)
                   & ({1'b0, i_wr_filter} < NF_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int t = 0; t < KERNEL_TAPS; t++) begin
                    r_weight[f][t] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_weight[i_wr_filter][i_wr_idx] <= i_wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < KERNEL_TAPS; gi++) begin : g_pix_ext
            assign w_pix_ext[gi] = PW'($signed({1'b0, w_window[gi*DATA_WIDTH +: DATA_WIDTH]}));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int t = 0; t < KERNEL_TAPS; t++) begin
                    r_prod[f][t] <= '0;
                end
            end
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= w_win_valid;
            r_s2_last  <= w_win_last;
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int t = 0; t < KERNEL_TAPS; t++) begin
                    r_prod[f][t] <= w_pix_ext[t] * PW'(r_weight[f][t]);
                end
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FILTERS; f++) begin
            w_sum[f] = '0;
            for (int t = 0; t < KERNEL_TAPS; t++) begin
                w_sum[f] = w_sum[f] + ACC_WIDTH'(r_prod[f][t]);
            end
            if ((RELU_EN != 0) && w_sum[f][ACC_WIDTH-1]) begin
                w_sum[f] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                r_result[f] <= '0;
            end
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_en) begin
            r_valid <= r_s2_valid;
            r_last  <= r_s2_last;
            if (r_s2_valid) begin
                for (int f = 0; f < NUM_FILTERS; f++) begin
                    r_result[f] <= w_sum[f];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_res_pack
            assign o_result[gi*ACC_WIDTH +: ACC_WIDTH] = r_result[gi];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule
